ascon_receiver: RTL and testbench

- Iterative ASCON-128 AEAD decryption/verification engine; the receive-side counterpart of the team's combinational ASCON transmitter.
- Accepts key, nonce, 3 associated-data blocks, 2 ciphertext blocks and a 128-bit tag.
- Produces 2 plaintext blocks and a tag-match flag, running one permutation round per clock.

---
 rtl/ascon_receiver.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ascon_receiver.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_receiver.sv
// ascon_receiver: iterative ASCON-128 AEAD decryption / tag verification.
// One permutation round is executed per clock. The run takes 49 edges
// from the accepting edge to the DONE cycle. The latency is fixed and does
// not depend on the data.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   start              run request, sampled only in IDLE
//   busy               high while a run is in progress (INIT..FIN)
//   done               one-cycle pulse; outputs are valid from this cycle on
//   key[127:0]         K = {Khi, Klo}
//   nonce[127:0]       N
//   d0, d1, d2         associated-data blocks, already padded by the caller
//   cyp0, cyp1         ciphertext blocks; cyp1 is final and already padded
//   tag[127:0]         received tag
//   plin0, plin1       recovered plaintext blocks
//   tag_ok             1 when the computed tag equals the tag input
//
// Build option ASCON_RX_TAG_GATE_EN:
//   When this option is defined and the tag mismatches, plin0 and plin1 are
//   forced to 0 in DONE, so unverified plaintext is never released.
module ascon_receiver #(
    parameter logic [63:0] IV        = 64'h80400c0600000000,
    parameter int          PA_ROUNDS = 12,
    parameter int          PB_ROUNDS = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         busy,
    output logic         done,
    input  logic [127:0] key,
    input  logic [127:0] nonce,
    input  logic [63:0]  d0,
    input  logic [63:0]  d1,
    input  logic [63:0]  d2,
    input  logic [63:0]  cyp0,
    input  logic [63:0]  cyp1,
    input  logic [127:0] tag,
    output logic [63:0]  plin0,
    output logic [63:0]  plin1,
    output logic         tag_ok
);

    typedef enum logic [2:0] {IDLE, INIT, AD, CT, FIN, DONE} state_e;
    // Element [i] holds state word Si.
    typedef logic [4:0][63:0] ascon_state_t;

    localparam logic [3:0] PA_LAST = 4'(PA_ROUNDS - 1);
    localparam logic [3:0] PA_END  = 4'(PA_ROUNDS);
    localparam logic [3:0] PB_LAST = 4'(PB_ROUNDS - 1);
    // The short permutation uses the constants of the last PB_ROUNDS rounds.
    localparam logic [3:0] PB_BASE = 4'(PA_ROUNDS - PB_ROUNDS);

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic ascon_state_t ascon_round(input ascon_state_t s_in, input logic [7:0] rc);
        ascon_state_t x;
        ascon_state_t t;
        x    = s_in;
        x[2] = x[2] ^ {56'd0, rc};
        // This is the bitsliced 5-bit S-box (chi with input and output whitening).
        x[0] = x[0] ^ x[4];
        x[4] = x[4] ^ x[3];
        x[2] = x[2] ^ x[1];
        t[0] = ~x[0] & x[1];
        t[1] = ~x[1] & x[2];
        t[2] = ~x[2] & x[3];
        t[3] = ~x[3] & x[4];
        t[4] = ~x[4] & x[0];
        x[0] = x[0] ^ t[1];
        x[1] = x[1] ^ t[2];
        x[2] = x[2] ^ t[3];
        x[3] = x[3] ^ t[4];
        x[4] = x[4] ^ t[0];
        x[1] = x[1] ^ x[0];
        x[0] = x[0] ^ x[4];
        x[3] = x[3] ^ x[2];
        x[2] = ~x[2];
        // Linear diffusion layer.
        x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
        x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
        x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
        x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
        x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
        return x;
    endfunction

    state_e        state_q, state_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [1:0]    blk_q, blk_d;
    ascon_state_t  s_q, s_d;
    logic [127:0]  key_q, key_d, tag_q, tag_d;
    logic [63:0]   d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
    logic [63:0]   cyp0_q, cyp0_d, cyp1_q, cyp1_d;
    logic [63:0]   plin0_q, plin0_d, plin1_q, plin1_d;
    logic          tag_ok_q, tag_ok_d;

    ascon_state_t  pre;       // state after any pre-round injections
    logic          do_round;
    logic [3:0]    c_idx;
    logic [7:0]    rc;
    logic [63:0]   d_sel;
    logic          tag_match;

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d  = state_q;
        rnd_d    = rnd_q;
        blk_d    = blk_q;
        s_d      = s_q;
        key_d    = key_q;
        tag_d    = tag_q;
        d0_d     = d0_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        cyp0_d   = cyp0_q;
        cyp1_d   = cyp1_q;
        plin0_d  = plin0_q;
        plin1_d  = plin1_q;
        tag_ok_d = tag_ok_q;
        pre      = s_q;
        do_round = 1'b0;
        c_idx    = rnd_q;

        case (blk_q)
            2'd0:    d_sel = d0_q;
            2'd1:    d_sel = d1_q;
            default: d_sel = d2_q;
        endcase
        tag_match = ({s_q[3] ^ key_q[127:64], s_q[4] ^ key_q[63:0]} == tag_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d    = key;
                    tag_d    = tag;
                    d0_d     = d0;
                    d1_d     = d1;
                    d2_d     = d2;
                    cyp0_d   = cyp0;
                    cyp1_d   = cyp1;
                    s_d      = {nonce[63:0], nonce[127:64], key[63:0], key[127:64], IV};
                    plin0_d  = '0;
                    plin1_d  = '0;
                    tag_ok_d = 1'b0;
                    rnd_d    = '0;
                    blk_d    = '0;
                    state_d  = INIT;
                end
            end
            INIT: begin
                do_round = 1'b1;
                if (rnd_q == PA_LAST) begin
                    rnd_d   = '0;
                    blk_d   = '0;
                    state_d = AD;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            AD: begin
                if (rnd_q == 4'd0) begin
                    pre[0] = pre[0] ^ d_sel;
                    // The key that closes initialization is folded into the first AD round.
                    if (blk_q == 2'd0) begin
                        pre[3] = pre[3] ^ key_q[127:64];
                        pre[4] = pre[4] ^ key_q[63:0];
                    end
                end
                do_round = 1'b1;
                c_idx    = PB_BASE + rnd_q;
                if (rnd_q == PB_LAST) begin
                    rnd_d = '0;
                    if (blk_q == 2'd2) state_d = CT;
                    else               blk_d   = blk_q + 2'd1;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            CT: begin
                if (rnd_q == 4'd0) begin
                    pre[4]  = pre[4] ^ 64'd1;      // domain separation AD -> data
                    plin0_d = pre[0] ^ cyp0_q;
                    pre[0]  = cyp0_q;
                end
                do_round = 1'b1;
                c_idx    = PB_BASE + rnd_q;
                if (rnd_q == PB_LAST) begin
                    rnd_d   = '0;
                    state_d = FIN;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            FIN: begin
                if (rnd_q == PA_END) begin
                    // All rounds are done. One extra edge registers the verdict.
                    tag_ok_d = tag_match;
`ifdef ASCON_RX_TAG_GATE_EN
                    if (!tag_match) begin
                        plin0_d = '0;
                        plin1_d = '0;
                    end
`endif
                    state_d = DONE;
                end else begin
                    if (rnd_q == 4'd0) begin
                        plin1_d = pre[0] ^ cyp1_q;
                        pre[0]  = cyp1_q;
                        pre[1]  = pre[1] ^ key_q[127:64];
                        pre[2]  = pre[2] ^ key_q[63:0];
                    end
                    do_round = 1'b1;
                    rnd_d    = rnd_q + 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rc = 8'hF0 - ({4'd0, c_idx} * 8'h0F);
        if (do_round) s_d = ascon_round(pre, rc);
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rnd_q    <= '0;
            blk_q    <= '0;
            s_q      <= '0;
            key_q    <= '0;
            tag_q    <= '0;
            d0_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            cyp0_q   <= '0;
            cyp1_q   <= '0;
            plin0_q  <= '0;
            plin1_q  <= '0;
            tag_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rnd_q    <= rnd_d;
            blk_q    <= blk_d;
            s_q      <= s_d;
            key_q    <= key_d;
            tag_q    <= tag_d;
            d0_q     <= d0_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            cyp0_q   <= cyp0_d;
            cyp1_q   <= cyp1_d;
            plin0_q  <= plin0_d;
            plin1_q  <= plin1_d;
            tag_ok_q <= tag_ok_d;
        end
    end

    assign busy   = (state_q != IDLE) && (state_q != DONE);
    assign done   = (state_q == DONE);
    assign plin0  = plin0_q;
    assign plin1  = plin1_q;
    assign tag_ok = tag_ok_q;

endmodule

// File: tb/tb_ascon_receiver.sv
// tb_ascon_receiver: bench for ascon_receiver. It uses a table of
// decryption vectors built from an independent behavioural ASCON model. A
// scoreboard queue is filled when a run is started. A monitor empties the
// queue on each done pulse. Hand-written sequences cover the start/busy,
// reset and back-to-back corner cases.
module tb_ascon_receiver;

    localparam logic [63:0] IV = 64'h80400c0600000000;
    localparam logic [63:0] P0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] P1 = 64'h8000000000000000;
    localparam int LATENCY = 49;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         busy, done, tag_ok;
    logic [127:0] key = '0, nonce = '0, tag = '0;
    logic [63:0]  d0 = '0, d1 = '0, d2 = '0, cyp0 = '0, cyp1 = '0;
    logic [63:0]  plin0, plin1;

    ascon_receiver dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .key(key), .nonce(nonce), .d0(d0), .d1(d1), .d2(d2),
        .cyp0(cyp0), .cyp1(cyp1), .tag(tag),
        .plin0(plin0), .plin1(plin1), .tag_ok(tag_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key, nonce;
        logic [63:0]  d0, d1, d2, c0, c1;
        logic [127:0] tag;
        logic [63:0]  p0, p1;
        logic         ok;
    } vec_t;

    typedef struct {
        logic [63:0] p0, p1;
        logic        ok;
    } exp_t;

    localparam int NVEC = 5;
    vec_t vecs [NVEC];
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural ASCON model ----------------
    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        logic [127:0] w;
        w = {v, v} >> n;
        return w[63:0];
    endfunction

    // Word Si lives at st[319-64*i -: 64].
    function automatic logic [319:0] m_perm(input logic [319:0] st, input int first, input int n);
        logic [63:0] x [0:4];
        logic [63:0] t [0:4];
        for (int i = 0; i < 5; i++) x[i] = st[319-64*i -: 64];
        for (int r = first; r < first + n; r++) begin
            x[2] ^= 64'(((15 - r) << 4) | r);
            x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
            for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
            for (int i = 0; i < 5; i++) x[i] ^= t[(i + 1) % 5];
            x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
            x[0] ^= ror(x[0], 19) ^ ror(x[0], 28);
            x[1] ^= ror(x[1], 61) ^ ror(x[1], 39);
            x[2] ^= ror(x[2], 1)  ^ ror(x[2], 6);
            x[3] ^= ror(x[3], 10) ^ ror(x[3], 17);
            x[4] ^= ror(x[4], 7)  ^ ror(x[4], 41);
        end
        for (int i = 0; i < 5; i++) st[319-64*i -: 64] = x[i];
        return st;
    endfunction

    // enc=1: in0/in1 are plaintext and out0/out1 are ciphertext.
    // enc=0: in0/in1 are ciphertext and out0/out1 are plaintext.
    task automatic m_ascon(input bit enc, input logic [127:0] k, input logic [127:0] n,
                           input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] a2,
                           input logic [63:0] in0, input logic [63:0] in1,
                           output logic [63:0] out0, output logic [63:0] out1,
                           output logic [127:0] tg);
        logic [319:0] st;
        logic [63:0]  ad [0:2];
        ad[0] = a0; ad[1] = a1; ad[2] = a2;
        st = {IV, k, n};
        st = m_perm(st, 0, 12);
        st[127:0] ^= k;
        for (int b = 0; b < 3; b++) begin
            st[319:256] ^= ad[b];
            st = m_perm(st, 6, 6);
        end
        st[0] = ~st[0];
        out0 = st[319:256] ^ in0;
        st[319:256] = enc ? out0 : in0;
        st = m_perm(st, 6, 6);
        out1 = st[319:256] ^ in1;
        st[319:256] = enc ? out1 : in1;
        st[255:128] ^= k;
        st = m_perm(st, 0, 12);
        tg = st[127:0] ^ k;
    endtask

    function automatic exp_t expect_of(input vec_t v);
        exp_t e;
        e.p0 = v.p0;
        e.p1 = v.p1;
        e.ok = v.ok;
`ifdef ASCON_RX_TAG_GATE_EN
        if (!v.ok) begin
            e.p0 = '0;
            e.p1 = '0;
        end
`endif
        return e;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending run");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("plin0", {64'd0, plin0}, {64'd0, e.p0});
                check("plin1", {64'd0, plin1}, {64'd0, e.p1});
                check("tag_ok", {127'd0, tag_ok}, {127'd0, e.ok});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input vec_t v);
        key = v.key; nonce = v.nonce;
        d0 = v.d0; d1 = v.d1; d2 = v.d2;
        cyp0 = v.c0; cyp1 = v.c1; tag = v.tag;
    endtask

    // Starts one run from IDLE and waits for done. lat is the number of
    // edges from E0 to done, or -1 when the budget expires.
    task automatic run_vec(input vec_t v, input bit push, output int lat);
        @(negedge clk);
        drive(v);
        start = 1'b1;
        check("busy_idle", {127'd0, busy}, 128'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) sb_q.push_back(expect_of(v));
        check("busy_run", {127'd0, busy}, 128'd1);
        lat = -1;
        for (int e = 1; e <= 80; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tagname);
        check({tagname, "_busy"},   {127'd0, busy},   128'd0);
        check({tagname, "_done"},   {127'd0, done},   128'd0);
        check({tagname, "_tag_ok"}, {127'd0, tag_ok}, 128'd0);
        check({tagname, "_plin0"},  {64'd0, plin0},   128'd0);
        check({tagname, "_plin1"},  {64'd0, plin1},   128'd0);
    endtask

    initial begin
        int lat;
        int ndone;
        int t_done [3];
        int nd;
        bit prev_done;
        logic [63:0]  c0, c1, q0, q1;
        logic [127:0] tg, tg2;

        // Vector table.
        vecs[0].key   = 128'h000102030405060708090A0B0C0D0E0F;
        vecs[0].nonce = 128'h000102030405060708090A0B0C0D0E0F;
        vecs[0].d0 = 64'h1111111111111111;
        vecs[0].d1 = 64'h2222222222222222;
        vecs[0].d2 = 64'h8000000000000000;
        m_ascon(1'b1, vecs[0].key, vecs[0].nonce, vecs[0].d0, vecs[0].d1, vecs[0].d2,
                P0, P1, c0, c1, tg);
        vecs[0].c0 = c0; vecs[0].c1 = c1; vecs[0].tag = tg;
        vecs[0].p0 = P0; vecs[0].p1 = P1; vecs[0].ok = 1'b1;

        // The tag has bit 0 flipped. The plaintext is unchanged but the tag is rejected.
        vecs[1] = vecs[0];
        vecs[1].tag = tg ^ 128'd1;
        vecs[1].ok  = 1'b0;

        // Ciphertext bit 63 is flipped. plin0 flips only in bit 63, and plin1 is garbled.
        vecs[2] = vecs[0];
        vecs[2].c0 = c0 ^ 64'h8000000000000000;
        m_ascon(1'b0, vecs[2].key, vecs[2].nonce, vecs[2].d0, vecs[2].d1, vecs[2].d2,
                vecs[2].c0, vecs[2].c1, q0, q1, tg2);
        vecs[2].p0 = P0 ^ 64'h8000000000000000;
        vecs[2].p1 = q1;
        vecs[2].ok = 1'b0;

        // Random valid round trips.
        for (int i = 3; i < NVEC; i++) begin
            vecs[i].key   = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].nonce = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].d0 = {$urandom, $urandom};
            vecs[i].d1 = {$urandom, $urandom};
            vecs[i].d2 = {$urandom, $urandom};
            vecs[i].p0 = {$urandom, $urandom};
            vecs[i].p1 = {$urandom, $urandom};
            m_ascon(1'b1, vecs[i].key, vecs[i].nonce, vecs[i].d0, vecs[i].d1, vecs[i].d2,
                    vecs[i].p0, vecs[i].p1, c0, c1, tg);
            vecs[i].c0 = c0; vecs[i].c1 = c1; vecs[i].tag = tg;
            vecs[i].ok = 1'b1;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven runs.
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], 1'b1, lat);
            check($sformatf("latency_v%0d", i), 128'(lat), 128'(LATENCY));
            @(posedge clk);
            #1;
            check($sformatf("done_width_v%0d", i), {127'd0, done}, 128'd0);
        end

        // Busy protection: a second start with another key is ignored.
        @(negedge clk);
        drive(vecs[0]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb_q.push_back(expect_of(vecs[0]));
        ndone = 0;
        lat = -1;
        for (int e = 1; e <= 120; e++) begin
            if (e == 10) begin
                key = ~vecs[0].key;
                nonce = ~vecs[0].nonce;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            if (e == 10) start = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) lat = e;
            end
        end
        check("busy_prot_latency", 128'(lat), 128'(LATENCY));
        check("busy_prot_done_count", 128'(ndone), 128'd1);

        // Reset in the middle of a run.
        @(negedge clk);
        drive(vecs[0]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("midrun_busy", {127'd0, busy}, 128'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("midrun_hold");
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], 1'b1, lat);
        check("post_reset_latency", 128'(lat), 128'(LATENCY));

        // Back-to-back runs with start held high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(vecs[3]);
        start = 1'b1;
        for (int i = 0; i < 3; i++) sb_q.push_back(expect_of(vecs[3]));
        @(posedge clk);
        nd = 0;
        prev_done = 1'b0;
        for (int e = 1; e <= 300 && nd < 3; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (prev_done) check("b2b_done_width", 128'd1, 128'd0);
                t_done[nd] = e;
                nd++;
                if (nd == 3) start = 1'b0;
            end
            prev_done = done;
        end
        start = 1'b0;
        check("b2b_done_count", 128'(nd), 128'd3);
        if (nd == 3) begin
            check("b2b_first", 128'(t_done[0]), 128'(LATENCY));
            check("b2b_period1", 128'(t_done[1] - t_done[0]), 128'd51);
            check("b2b_period2", 128'(t_done[2] - t_done[1]), 128'd51);
        end
        @(posedge clk);
        #1;
        check("b2b_done_low", {127'd0, done}, 128'd0);
        repeat (4) @(posedge clk);
        #1;
        check("b2b_idle", {127'd0, busy}, 128'd0);

        // Every expected result was consumed by a done pulse.
        repeat (2) @(posedge clk);
        check("scoreboard_drained", 128'(sb_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
